// File: rtl/fm_playback_src_if.sv
// Configuration and playback signals of the floating-monitor playback source,
// bundled so the configuring side (master) and the source (slave) share one port.
interface fm_playback_src_if #(
    parameter int DATA_WIDTH = 256,
    parameter int AXI_DW     = 32,
    parameter int DEPTH_LOG2 = 6
);
    localparam int ADDR_W = DEPTH_LOG2 + $clog2(DATA_WIDTH / AXI_DW);

    logic                  cfg_wr_en;
    logic [ADDR_W-1:0]     cfg_wr_addr;
    logic [AXI_DW-1:0]     cfg_wr_data;
    logic [DEPTH_LOG2:0]   cfg_len;
    logic [7:0]            cfg_gap;
    logic [1:0]            playback_mode;
    logic                  start;
    logic                  stop;
    logic [DATA_WIDTH-1:0] pb_data;
    logic                  pb_vld;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [31:0]           pb_word_cnt;

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_len, cfg_gap,
               playback_mode, start, stop,
        input  pb_data, pb_vld, busy, done, err, pb_word_cnt
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_len, cfg_gap,
               playback_mode, start, stop,
        output pb_data, pb_vld, busy, done, err, pb_word_cnt
    );
endinterface

// File: rtl/fm_playback_src.sv
// Pattern-memory playback source: lane-wise loaded words replayed as a valid stream,
// one-shot or looping, with an idle gap. Define FM_PB_WORDCNT_EN to build the word counter.
module fm_playback_src #(
    parameter int DATA_WIDTH = 256,
    parameter int AXI_DW     = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic              clk_hs,
    input  logic              rst_hs,
    fm_playback_src_if.slave  bus
);
    localparam int LANES     = DATA_WIDTH / AXI_DW;
    localparam int LANE_LOG2 = $clog2(LANES);
    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] MAX_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0]   len_last_q;
    logic                    last_q, last_d;
    logic                    loop_q;
    logic [7:0]              gap_q;
    logic [7:0]              gap_cnt_q, gap_cnt_d;
    logic                    pb_vld_q;
    logic                    busy_q;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    accept;
    logic                    rd_en;
    logic                    start_ok;
    logic                    wr_ok;
    logic [DEPTH_LOG2-1:0]   wr_word;
    logic [LANE_LOG2-1:0]    wr_lane;
    logic [LANES-1:0][AXI_DW-1:0] lane_data;

    assign wr_word  = bus.cfg_wr_addr[LANE_LOG2 +: DEPTH_LOG2];
    assign wr_lane  = bus.cfg_wr_addr[LANE_LOG2-1:0];
    assign wr_ok    = bus.cfg_wr_en && !busy_q;
    assign start_ok = ((bus.playback_mode == 2'b01) || (bus.playback_mode == 2'b10)) &&
                      (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN);

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        last_d    = last_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        err_d     = bus.cfg_wr_en && busy_q;
        accept    = 1'b0;
        rd_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A simultaneous stop cancels the start without flagging an error.
                if (!bus.stop && bus.start) begin
                    if (start_ok) begin
                        accept   = 1'b1;
                        state_d  = S_PRIME;
                        rd_ptr_d = '0;
                        last_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PRIME: begin
                rd_en   = 1'b1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (last_q && !loop_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (gap_q != 8'd0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = gap_q;
                end else begin
                    rd_en = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 8'd1) begin
                    state_d = S_STREAM;
                    rd_en   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pointer advances with every issued read; the word fetched now is the last
        // one when the pointer sits on len-1.
        if (rd_en) begin
            last_d   = (rd_ptr_q == len_last_q);
            rd_ptr_d = last_d ? '0 : rd_ptr_q + 1'b1;
        end

        if (bus.stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            rd_en   = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_hs) begin
        if (rst_hs) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            last_q     <= 1'b0;
            gap_cnt_q  <= 8'd0;
            pb_vld_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            loop_q     <= 1'b0;
            len_last_q <= '0;
            gap_q      <= 8'd0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            last_q    <= last_d;
            gap_cnt_q <= gap_cnt_d;
            pb_vld_q  <= rd_en;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= done_d;
            err_q     <= err_d;
            if (accept) begin
                loop_q     <= (bus.playback_mode == 2'b10);
                len_last_q <= bus.cfg_len[DEPTH_LOG2-1:0] - 1'b1;
                gap_q      <= bus.cfg_gap;
            end
        end
    end

    // One narrow RAM per lane so a lane write never touches its neighbours; the
    // registered read port doubles as the pb_data holding register.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [AXI_DW-1:0] mem [0:DEPTH-1];
            logic [AXI_DW-1:0] rd_q;

            always_ff @(posedge clk_hs) begin
                if (wr_ok && (wr_lane == LANE_LOG2'(gi))) begin
                    mem[wr_word] <= bus.cfg_wr_data;
                end
            end

            always_ff @(posedge clk_hs) begin
                if (rst_hs) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= mem[rd_ptr_q];
                end
            end

            assign lane_data[gi] = rd_q;
        end
    endgenerate

    assign bus.pb_data = lane_data;
    assign bus.pb_vld  = pb_vld_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

`ifdef FM_PB_WORDCNT_EN
    logic [31:0] word_cnt_q;

    always_ff @(posedge clk_hs) begin
        if (rst_hs || accept) begin
            word_cnt_q <= 32'd0;
        end else if (pb_vld_q && (word_cnt_q != 32'hFFFF_FFFF)) begin
            word_cnt_q <= word_cnt_q + 32'd1;
        end
    end

    assign bus.pb_word_cnt = word_cnt_q;
`else
    assign bus.pb_word_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fm_playback_src.sv
// Directed bench for fm_playback_src: once/loop replay, gaps, stop, rejected
// starts and writes, mid-replay reset and the optional word counter.
module tb_fm_playback_src;
    localparam int DW  = 256;
    localparam int ADW = 32;
    localparam int DL2 = 6;
`ifdef FM_PB_WORDCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fm_playback_src_if #(.DATA_WIDTH(DW), .AXI_DW(ADW), .DEPTH_LOG2(DL2)) bus ();

    fm_playback_src #(.DATA_WIDTH(DW), .AXI_DW(ADW), .DEPTH_LOG2(DL2)) dut (
        .clk_hs (clk),
        .rst_hs (rst),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_mem [0:7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_lane(input int w, input int l, input logic [31:0] d);
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_addr = 9'(w * 8 + l);
        bus.cfg_wr_data = d;
        step();
        bus.cfg_wr_en   = 1'b0;
    endtask

    // Leaves the bench in cycle T+1 of a start issued in cycle T.
    task automatic pulse_start(input logic [1:0] m, input logic [6:0] len, input logic [7:0] gap);
        bus.playback_mode = m;
        bus.cfg_len       = len;
        bus.cfg_gap       = gap;
        bus.start         = 1'b1;
        step();
        bus.start         = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (bus.pb_vld !== 1'b0) begin n_errors++; $display("FAIL reset_vld got %b exp 0", bus.pb_vld); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin n_errors++; $display("FAIL reset_done_err got %b%b exp 00", bus.done, bus.err); end
        n_checks++; if (bus.pb_data !== '0) begin n_errors++; $display("FAIL reset_data got %h exp 0", bus.pb_data); end
        n_checks++; if (bus.pb_word_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_cnt got %0d exp 0", bus.pb_word_cnt); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_load();
        for (int w = 0; w < 8; w++) begin
            for (int l = 0; l < 8; l++) begin
                wr_lane(w, l, {16'(w), 16'(l)});
                exp_mem[w][l*32 +: 32] = {16'(w), 16'(l)};
            end
        end
        n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL load_err got %b exp 0", bus.err); end
        step();
    endtask

    task automatic test_once();
        pulse_start(2'b01, 7'd4, 8'd0);
        n_checks++; if (bus.busy !== 1'b1 || bus.pb_vld !== 1'b0) begin n_errors++; $display("FAIL once_prime busy/vld got %b%b exp 10", bus.busy, bus.pb_vld); end
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.pb_vld !== 1'b1 || bus.busy !== 1'b1) begin n_errors++; $display("FAIL once_vld[%0d] vld/busy got %b%b exp 11", i, bus.pb_vld, bus.busy); end
            n_checks++; if (bus.pb_data !== exp_mem[i]) begin n_errors++; $display("FAIL once_data[%0d] got %h exp %h", i, bus.pb_data, exp_mem[i]); end
            step();
        end
        n_checks++; if (bus.pb_vld !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b1) begin n_errors++; $display("FAIL once_end vld/busy/done got %b%b%b exp 001", bus.pb_vld, bus.busy, bus.done); end
        step();
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL once_done_pulse got %b exp 0", bus.done); end
        step();
    endtask

    task automatic test_loop_gap();
        logic exp_v;
        pulse_start(2'b10, 7'd2, 8'd3);
        step();
        for (int k = 0; k < 18; k++) begin
            exp_v = ((k % 4) == 0);
            n_checks++; if (bus.pb_vld !== exp_v || bus.busy !== 1'b1) begin n_errors++; $display("FAIL loop_vld[%0d] vld/busy got %b%b exp %b1", k, bus.pb_vld, bus.busy, exp_v); end
            if (exp_v) begin
                n_checks++; if (bus.pb_data !== exp_mem[(k / 4) % 2]) begin n_errors++; $display("FAIL loop_data[%0d] got %h exp %h", k, bus.pb_data, exp_mem[(k / 4) % 2]); end
            end
            if (k == 17) bus.stop = 1'b1;
            step();
        end
        bus.stop = 1'b0;
        n_checks++; if (bus.pb_vld !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_errors++; $display("FAIL stop_gap vld/busy/done got %b%b%b exp 000", bus.pb_vld, bus.busy, bus.done); end
        n_checks++; if (bus.pb_data !== exp_mem[0]) begin n_errors++; $display("FAIL stop_hold got %h exp %h", bus.pb_data, exp_mem[0]); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (bus.pb_vld !== 1'b0 || bus.done !== 1'b0) begin n_errors++; $display("FAIL stop_after[%0d] vld/done got %b%b exp 00", i, bus.pb_vld, bus.done); end
        end
        step();
    endtask

    task automatic test_err();
        logic [1:0] modes [3];
        logic [6:0] lens  [3];
        modes = '{2'b01, 2'b01, 2'b11};
        lens  = '{7'd0, 7'd65, 7'd4};
        for (int i = 0; i < 3; i++) begin
            pulse_start(modes[i], lens[i], 8'd0);
            n_checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.pb_vld !== 1'b0) begin n_errors++; $display("FAIL err_start[%0d] err/busy/vld got %b%b%b exp 100", i, bus.err, bus.busy, bus.pb_vld); end
            step();
            n_checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.pb_vld !== 1'b0) begin n_errors++; $display("FAIL err_after[%0d] err/busy/vld got %b%b%b exp 000", i, bus.err, bus.busy, bus.pb_vld); end
        end
        step();
    endtask

    task automatic test_wr_busy();
        bit seen;
        pulse_start(2'b01, 7'd4, 8'd2);
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_addr = 9'(1 * 8 + 0);
        bus.cfg_wr_data = 32'h1234_5678;
        step();
        bus.cfg_wr_en   = 1'b0;
        n_checks++; if (bus.err !== 1'b1) begin n_errors++; $display("FAIL wr_busy_err got %b exp 1", bus.err); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) begin seen = 1'b1; break; end
            step();
        end
        n_checks++; if (!seen) begin n_errors++; $display("FAIL wr_busy_done_timeout got 0 exp 1"); end
        step();
        wr_lane(7, 0, 32'hDEAD_BEEF);
        exp_mem[7][31:0] = 32'hDEAD_BEEF;
        n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL wr_idle_err got %b exp 0", bus.err); end
        pulse_start(2'b01, 7'd8, 8'd0);
        step();
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (bus.pb_vld !== 1'b1 || bus.pb_data !== exp_mem[i]) begin n_errors++; $display("FAIL wr_replay[%0d] vld %b got %h exp %h", i, bus.pb_vld, bus.pb_data, exp_mem[i]); end
            step();
        end
        n_checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL wr_replay_done done/busy got %b%b exp 10", bus.done, bus.busy); end
        step();
    endtask

    task automatic test_reset_mid();
        pulse_start(2'b10, 7'd4, 8'd0);
        step();
        step();
        step();
        n_checks++; if (bus.pb_vld !== 1'b1 || bus.pb_data !== exp_mem[2]) begin n_errors++; $display("FAIL rstmid_word2 vld %b got %h exp %h", bus.pb_vld, bus.pb_data, exp_mem[2]); end
        rst = 1'b1;
        step();
        n_checks++; if (bus.pb_vld !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin n_errors++; $display("FAIL rstmid_flags vld/busy/done/err got %b%b%b%b exp 0000", bus.pb_vld, bus.busy, bus.done, bus.err); end
        n_checks++; if (bus.pb_data !== '0 || bus.pb_word_cnt !== 32'd0) begin n_errors++; $display("FAIL rstmid_data got %h cnt %0d exp 0", bus.pb_data, bus.pb_word_cnt); end
        rst = 1'b0;
        step();
        pulse_start(2'b01, 7'd4, 8'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.pb_vld !== 1'b1 || bus.pb_data !== exp_mem[i]) begin n_errors++; $display("FAIL rstmid_replay[%0d] vld %b got %h exp %h", i, bus.pb_vld, bus.pb_data, exp_mem[i]); end
            step();
        end
        n_checks++; if (bus.done !== 1'b1) begin n_errors++; $display("FAIL rstmid_done got %b exp 1", bus.done); end
        step();
    endtask

    task automatic test_wordcnt();
        int  nv;
        bit  seen;
        logic [31:0] exp_cnt;
        exp_cnt = CNT_EN ? 32'd5 : 32'd0;
        for (int run = 0; run < 2; run++) begin
            pulse_start(2'b01, 7'd5, 8'd1);
            n_checks++; if (bus.pb_word_cnt !== 32'd0) begin n_errors++; $display("FAIL cnt_clear[%0d] got %0d exp 0", run, bus.pb_word_cnt); end
            nv   = 0;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (bus.done === 1'b1) begin seen = 1'b1; break; end
                if (bus.pb_vld === 1'b1) nv++;
                step();
            end
            n_checks++; if (!seen || nv != 5) begin n_errors++; $display("FAIL cnt_run[%0d] done %b vld_cycles got %0d exp 5", run, seen, nv); end
            n_checks++; if (bus.pb_word_cnt !== exp_cnt) begin n_errors++; $display("FAIL cnt_value[%0d] got %0d exp %0d", run, bus.pb_word_cnt, exp_cnt); end
            step();
            step();
            n_checks++; if (bus.pb_word_cnt !== exp_cnt) begin n_errors++; $display("FAIL cnt_hold[%0d] got %0d exp %0d", run, bus.pb_word_cnt, exp_cnt); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        bus.cfg_wr_en     = 1'b0;
        bus.cfg_wr_addr   = '0;
        bus.cfg_wr_data   = '0;
        bus.cfg_len       = '0;
        bus.cfg_gap       = '0;
        bus.playback_mode = 2'b00;
        bus.start         = 1'b0;
        bus.stop          = 1'b0;
        test_reset();
        test_load();
        test_once();
        test_loop_gap();
        test_err();
        test_wr_busy();
        test_reset_mid();
        test_wordcnt();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fm_playback_src.md
Name: fm_playback_src

Overview:
- Playback source for the floating-monitor path; the transmit side of the capture stream the spy buffers record.
- Configuration writes (AXI-width lanes on clk_hs) load a local pattern memory of DATA_WIDTH words.
- On start, the block replays those words as a data/valid stream into the user-logic monitor input.
- Supports one-shot and looping replay, plus a programmable idle gap between words.

Parameters:
- DATA_WIDTH, 256, width of each replayed word.
- AXI_DW, 32, configuration write lane width. DATA_WIDTH/AXI_DW = LANES must be a power of 2.
- DEPTH_LOG2, 6, log2 of the pattern memory depth in words (64).

Ports:
- clk_hs  in  1  single clock for all logic.
- rst_hs  in  1  synchronous, active-high reset.
- cfg_wr_en  in  1  lane write strobe.
- cfg_wr_addr  in  DEPTH_LOG2+log2(LANES)  {word index, lane index}; lane 0 = bits [AXI_DW-1:0].
- cfg_wr_data  in  AXI_DW  lane data.
- cfg_len  in  DEPTH_LOG2+1  number of words to replay, valid range 1..2^DEPTH_LOG2.
- cfg_gap  in  8  idle cycles inserted after every valid word.
- playback_mode  in  2  00 off, 01 once, 10 loop, 11 reserved (treated as off).
- start  in  1  single-cycle start request.
- stop  in  1  single-cycle abort request.
- pb_data  out  DATA_WIDTH  replayed word.
- pb_vld  out  1  pb_data valid.
- busy  out  1  replay in progress.
- done  out  1  one-cycle pulse at end of a once-mode replay.
- err  out  1  one-cycle pulse on a rejected start or a rejected cfg write.
- pb_word_cnt  out  32  words emitted (see Optional Feature).

Behaviour:
- Reset: pb_data=0, pb_vld=0, busy=0, done=0, err=0, pb_word_cnt=0, FSM in IDLE.
  - Memory contents are not cleared.
  - Reset asserted mid-replay takes effect in the next cycle: all outputs are 0 from then on, no done pulse.
- Memory write:
  - A cfg_wr_en lane write updates only the addressed AXI_DW slice of the addressed word. Write is visible to a read one cycle later.
  - While busy=1, writes are dropped and err pulses for one cycle.
- FSM states: IDLE, PRIME, STREAM, GAP.
- IDLE:
  - start with playback_mode in {01,10} and cfg_len in 1..2^DEPTH_LOG2 → PRIME. Latch mode, len and gap; busy=1 from the next cycle.
  - start with mode off/reserved or len out of range → stay in IDLE, err pulses the next cycle.
- PRIME: issue read of word 0 (1-cycle RAM latency) → STREAM.
- STREAM:
  - pb_vld=1 and pb_data=word[rd_ptr] for exactly one cycle. pb_data holds its last value while pb_vld=0.
  - Start at cycle T gives first pb_vld at T+2.
  - Next state: if gap>0 → GAP, otherwise the next word streams the following cycle (back-to-back, no bubble).
- GAP: count gap cycles with pb_vld=0, then STREAM the next word.
- Pointer: rd_ptr increments after each word.
  - On rd_ptr = len-1 in loop mode, wrap to 0; the gap still applies across the wrap.
  - On rd_ptr = len-1 in once mode: in the cycle after the last valid word, busy=0, done=1, FSM → IDLE. No trailing gap.
- stop (any non-IDLE state) has priority over all other transitions: next cycle pb_vld=0, busy=0, FSM → IDLE, no done.
- start while busy is ignored (no err).
- start and stop in the same IDLE cycle: stop wins, start is ignored.
- Mode and cfg changes during replay have no effect until the next start.

Optional Feature:
- Macro FM_PB_WORDCNT_EN.
- Defined:
  - pb_word_cnt increments on every pb_vld cycle and saturates at 0xFFFFFFFF.
  - It clears on reset and on each accepted start.
- Undefined: pb_word_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Load words 0..3 with lane pattern {word,lane} (e.g. word2 lane5 = 0x00020005); len=4, gap=0, mode=once, start at T → pb_vld high T+2..T+5 with words 0..3 in order; done=1 at T+6; busy high T+1..T+5.
- Same load with len=2, gap=3, mode=loop → pb_vld pattern 1,0,0,0 repeating; words alternate 0,1,0,1; stop mid-GAP → pb_vld stays 0 and busy=0 the next cycle, no done.
- start with len=0, then with len=65, then with mode=11 → each gives err pulse 1 cycle later, busy stays 0, pb_vld stays 0.
- cfg_wr_en during an active replay → err pulse, memory word unchanged on the next replay; lane write to word7 lane0 with 0xDEADBEEF while idle → only bits [31:0] of word 7 change on replay.
- rst_hs asserted at the 3rd valid word of a looping replay → all outputs 0 the next cycle; a subsequent start replays the memory contents intact from word 0.
- With FM_PB_WORDCNT_EN: once-mode run, len=5, gap=1 → pb_word_cnt=5 after done; second start clears it to 0, then it counts again. Without the macro: pb_word_cnt stays 0.
